// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 set-2 scan code decoder: prefix bytes,
// shift key codes and the byte-handler FSM encoding.
package ps2_pkg;

  localparam logic [7:0] PFX_EXT    = 8'hE0;
  localparam logic [7:0] PFX_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT  = 8'h12;
  localparam logic [7:0] SC_RSHIFT  = 8'h59;
  localparam logic [7:0] SC_ERR_LO  = 8'h00;
  localparam logic [7:0] SC_ERR_HI  = 8'hFF;
  localparam logic [7:0] CASE_DELTA = 8'h20;

  typedef enum logic {
    IDLE = 1'b0,
    PROC = 1'b1
  } state_t;

endpackage

// File: rtl/scancode_to_ascii.sv
// Combinational set-2 scan code to ASCII ROM. Extended codes and anything
// not listed map to 0x00; letters become uppercase while shift is held.
module scancode_to_ascii
  import ps2_pkg::*;
(
  input  logic [7:0] scan_code,
  input  logic       ext,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic [7:0] letter;
  logic [7:0] other;

  always_comb begin
    letter = 8'h00;
    unique case (scan_code)
      8'h1C: letter = 8'h61;
      8'h32: letter = 8'h62;
      8'h21: letter = 8'h63;
      8'h23: letter = 8'h64;
      8'h24: letter = 8'h65;
      8'h2B: letter = 8'h66;
      8'h34: letter = 8'h67;
      8'h33: letter = 8'h68;
      8'h43: letter = 8'h69;
      8'h3B: letter = 8'h6A;
      8'h42: letter = 8'h6B;
      8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D;
      8'h31: letter = 8'h6E;
      8'h44: letter = 8'h6F;
      8'h4D: letter = 8'h70;
      8'h15: letter = 8'h71;
      8'h2D: letter = 8'h72;
      8'h1B: letter = 8'h73;
      8'h2C: letter = 8'h74;
      8'h3C: letter = 8'h75;
      8'h2A: letter = 8'h76;
      8'h1D: letter = 8'h77;
      8'h22: letter = 8'h78;
      8'h35: letter = 8'h79;
      8'h1A: letter = 8'h7A;
      default: letter = 8'h00;
    endcase
  end

  always_comb begin
    other = 8'h00;
    unique case (scan_code)
      8'h45: other = 8'h30;
      8'h16: other = 8'h31;
      8'h1E: other = 8'h32;
      8'h26: other = 8'h33;
      8'h25: other = 8'h34;
      8'h2E: other = 8'h35;
      8'h36: other = 8'h36;
      8'h3D: other = 8'h37;
      8'h3E: other = 8'h38;
      8'h46: other = 8'h39;
      8'h29: other = 8'h20;
      8'h5A: other = 8'h0D;
      8'h66: other = 8'h08;
      default: other = 8'h00;
    endcase
  end

  always_comb begin
    ascii = 8'h00;
    if (!ext) begin
      if (letter != 8'h00) begin
        ascii = shift ? (letter - CASE_DELTA) : letter;
      end else begin
        ascii = other;
      end
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Pops bytes from a PS/2 keyboard FIFO and decodes set-2 make/break
// sequences into last-key state, a press counter and an ASCII view.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       kb_data,
  input  logic             kb_ready,
  input  logic             kb_overflow,
  output logic             nextdata_n,
  output logic [7:0]       scan_code,
  output logic             ext,
  output logic [7:0]       ascii,
  output logic             key_down,
  output logic             key_event,
  output logic [CNT_W-1:0] press_count,
  output logic             err_ovf
);

  state_t           state, state_nxt;
  logic [7:0]       byte_p0;
  logic             pop;
  logic             e0_seen, f0_seen, e0_nxt, f0_nxt;
  logic             lshift, rshift, lshift_nxt, rshift_nxt;
  logic [7:0]       scan_nxt;
  logic             ext_nxt, down_nxt, event_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             same_key;

  // Pop is gated by clrn so the FIFO is never drained while held in reset.
  assign pop        = kb_ready & (state == IDLE) & clrn;
  assign nextdata_n = ~pop;
  assign same_key   = key_down & ({e0_seen, byte_p0} == {ext, scan_code});

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (pop) state_nxt = PROC;
      PROC: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    e0_nxt     = e0_seen;
    f0_nxt     = f0_seen;
    lshift_nxt = lshift;
    rshift_nxt = rshift;
    scan_nxt   = scan_code;
    ext_nxt    = ext;
    down_nxt   = key_down;
    count_nxt  = press_count;
    event_nxt  = 1'b0;
    if (state == PROC) begin
      if (byte_p0 == PFX_EXT) begin
        e0_nxt = 1'b1;
      end else if (byte_p0 == PFX_BRK) begin
        f0_nxt = 1'b1;
      end else begin
        e0_nxt = 1'b0;
        f0_nxt = 1'b0;
        if (byte_p0 == SC_ERR_LO || byte_p0 == SC_ERR_HI) begin
          // keyboard error byte: sequence abandoned, nothing else changes
        end else if (!e0_seen && byte_p0 == SC_LSHIFT) begin
          lshift_nxt = ~f0_seen;
        end else if (!e0_seen && byte_p0 == SC_RSHIFT) begin
          rshift_nxt = ~f0_seen;
        end else if (!f0_seen) begin
          if (!same_key) begin
            scan_nxt  = byte_p0;
            ext_nxt   = e0_seen;
            down_nxt  = 1'b1;
            count_nxt = press_count + 1'b1;
            event_nxt = 1'b1;
          end
        end else if (same_key) begin
          down_nxt  = 1'b0;
          event_nxt = 1'b1;
        end
      end
    end
  end

  // Byte capture: only meaningful while in PROC, so it needs no reset.
  always_ff @(posedge clk) begin
    if (pop) byte_p0 <= kb_data;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= IDLE;
      e0_seen     <= 1'b0;
      f0_seen     <= 1'b0;
      lshift      <= 1'b0;
      rshift      <= 1'b0;
      scan_code   <= 8'h00;
      ext         <= 1'b0;
      key_down    <= 1'b0;
      key_event   <= 1'b0;
      press_count <= '0;
      err_ovf     <= 1'b0;
    end else begin
      state       <= state_nxt;
      e0_seen     <= e0_nxt;
      f0_seen     <= f0_nxt;
      lshift      <= lshift_nxt;
      rshift      <= rshift_nxt;
      scan_code   <= scan_nxt;
      ext         <= ext_nxt;
      key_down    <= down_nxt;
      key_event   <= event_nxt;
      press_count <= count_nxt;
      if (kb_overflow) err_ovf <= 1'b1;
    end
  end

  scancode_to_ascii u_rom (
    .scan_code (scan_code),
    .ext       (ext),
    .shift     (lshift | rshift),
    .ascii     (ascii)
  );

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: byte sequences with hand-derived
// expected outputs, one task per scenario.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       clrn;
  logic [7:0] kb_data;
  logic       kb_ready;
  logic       kb_overflow;
  logic       nextdata_n;
  logic [7:0] scan_code;
  logic       ext;
  logic [7:0] ascii;
  logic       key_down;
  logic       key_event;
  logic [7:0] press_count;
  logic       err_ovf;

  int checks   = 0;
  int failures = 0;
  int events   = 0;

  ps2_scancode_decoder #(.CNT_W(8)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .kb_data     (kb_data),
    .kb_ready    (kb_ready),
    .kb_overflow (kb_overflow),
    .nextdata_n  (nextdata_n),
    .scan_code   (scan_code),
    .ext         (ext),
    .ascii       (ascii),
    .key_down    (key_down),
    .key_event   (key_event),
    .press_count (press_count),
    .err_ovf     (err_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0;
    kb_ready = 1'b0;
    kb_data = 8'h00;
    kb_overflow = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    events = 0;
  endtask

  // One byte through the FIFO handshake; outputs are sampled 1 ns after the
  // decode edge and key_event is accumulated.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    kb_data  = b;
    kb_ready = 1'b1;
    #1;
    checks++;
    if (nextdata_n !== 1'b0) begin
      failures++;
      $display("FAIL pop_req byte=%h got=%b want=0", b, nextdata_n);
    end
    @(posedge clk);
    #1 kb_ready = 1'b0;
    @(posedge clk);
    #1;
    if (key_event === 1'b1) events++;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    kb_ready = 1'b1;
    kb_data = 8'h1C;
    kb_overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (nextdata_n !== 1'b1) begin failures++; $display("FAIL reset_nextdata got=%b want=1", nextdata_n); end
    checks++;
    if ({scan_code, ext, key_down, key_event, press_count, err_ovf, ascii} !== 28'h0) begin
      failures++;
      $display("FAIL reset_outputs got scan=%h ext=%b down=%b ev=%b cnt=%h ovf=%b ascii=%h want all 0",
               scan_code, ext, key_down, key_event, press_count, err_ovf, ascii);
    end
    clrn = 1'b1;
    kb_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_press_release();
    do_reset();
    send_byte(8'h1C);
    checks++;
    if ({scan_code, ascii, press_count, key_down, key_event} !== {8'h1C, 8'h61, 8'd1, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL press_make got scan=%h ascii=%h cnt=%0d down=%b ev=%b want 1c 61 1 1 1",
               scan_code, ascii, press_count, key_down, key_event);
    end
    @(posedge clk);
    #1;
    checks++;
    if (key_event !== 1'b0) begin failures++; $display("FAIL event_width got=%b want=0", key_event); end
    send_byte(8'hF0);
    send_byte(8'h1C);
    checks++;
    if ({key_down, key_event, press_count, scan_code} !== {1'b0, 1'b1, 8'd1, 8'h1C}) begin
      failures++;
      $display("FAIL press_break got down=%b ev=%b cnt=%0d scan=%h want 0 1 1 1c",
               key_down, key_event, press_count, scan_code);
    end
    checks++;
    if (events !== 2) begin failures++; $display("FAIL press_events got=%0d want=2", events); end
  endtask

  task automatic test_typematic();
    do_reset();
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'h1C);
    checks++;
    if ({press_count, key_down} !== {8'd1, 1'b1}) begin
      failures++;
      $display("FAIL typematic_hold got cnt=%0d down=%b want 1 1", press_count, key_down);
    end
    send_byte(8'hF0);
    send_byte(8'h1C);
    checks++;
    if ({press_count, key_down} !== {8'd1, 1'b0} || events !== 2) begin
      failures++;
      $display("FAIL typematic_end got cnt=%0d down=%b events=%0d want 1 0 2", press_count, key_down, events);
    end
  endtask

  task automatic test_shift();
    do_reset();
    send_byte(8'h12);
    checks++;
    if ({scan_code, press_count, key_event} !== {8'h00, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL shift_hidden got scan=%h cnt=%0d ev=%b want 00 0 0", scan_code, press_count, key_event);
    end
    send_byte(8'h32);
    checks++;
    if ({scan_code, ascii, press_count} !== {8'h32, 8'h42, 8'd1}) begin
      failures++;
      $display("FAIL shift_upper got scan=%h ascii=%h cnt=%0d want 32 42 1", scan_code, ascii, press_count);
    end
    send_byte(8'hF0);
    send_byte(8'h32);
    send_byte(8'hF0);
    send_byte(8'h12);
    checks++;
    if ({scan_code, ascii, key_down} !== {8'h32, 8'h62, 1'b0}) begin
      failures++;
      $display("FAIL shift_release got scan=%h ascii=%h down=%b want 32 62 0", scan_code, ascii, key_down);
    end
    send_byte(8'h32);
    checks++;
    if ({scan_code, ascii, press_count, key_down} !== {8'h32, 8'h62, 8'd2, 1'b1}) begin
      failures++;
      $display("FAIL shift_lower got scan=%h ascii=%h cnt=%0d down=%b want 32 62 2 1",
               scan_code, ascii, press_count, key_down);
    end
    send_byte(8'h59);
    checks++;
    if (ascii !== 8'h42) begin failures++; $display("FAIL rshift_upper got=%h want=42", ascii); end
  endtask

  task automatic test_extended();
    do_reset();
    send_byte(8'hE0);
    send_byte(8'h75);
    checks++;
    if ({ext, scan_code, ascii, key_down, press_count} !== {1'b1, 8'h75, 8'h00, 1'b1, 8'd1}) begin
      failures++;
      $display("FAIL ext_make got ext=%b scan=%h ascii=%h down=%b cnt=%0d want 1 75 00 1 1",
               ext, scan_code, ascii, key_down, press_count);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    checks++;
    if ({ext, key_down, key_event} !== {1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL ext_break got ext=%b down=%b ev=%b want 1 0 1", ext, key_down, key_event);
    end
    send_byte(8'h75);
    checks++;
    if ({ext, scan_code, key_down, press_count} !== {1'b0, 8'h75, 1'b1, 8'd2}) begin
      failures++;
      $display("FAIL ext_plain got ext=%b scan=%h down=%b cnt=%0d want 0 75 1 2",
               ext, scan_code, key_down, press_count);
    end
    // a non-matching break and an error byte both leave the key held
    send_byte(8'hF0);
    send_byte(8'h1C);
    send_byte(8'hE0);
    send_byte(8'hFF);
    send_byte(8'h75);
    checks++;
    if ({ext, key_down, press_count} !== {1'b0, 1'b1, 8'd2}) begin
      failures++;
      $display("FAIL err_byte got ext=%b down=%b cnt=%0d want 0 1 2", ext, key_down, press_count);
    end
  endtask

  task automatic test_ascii_map();
    logic [7:0] codes [4] = '{8'h45, 8'h29, 8'h5A, 8'h3D};
    logic [7:0] exp   [4] = '{8'h30, 8'h20, 8'h0D, 8'h37};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_byte(codes[i]);
      checks++;
      if (ascii !== exp[i]) begin
        failures++;
        $display("FAIL ascii_map code=%h got=%h want=%h", codes[i], ascii, exp[i]);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send_byte((i % 2 == 0) ? 8'h1C : 8'h32);
      if (i == 254) begin
        checks++;
        if (press_count !== 8'hFF) begin failures++; $display("FAIL wrap_ff got=%h want=ff", press_count); end
      end
    end
    checks++;
    if (press_count !== 8'h00) begin failures++; $display("FAIL wrap_zero got=%h want=00", press_count); end
    checks++;
    if (events !== 256) begin failures++; $display("FAIL wrap_events got=%0d want=256", events); end
  endtask

  task automatic test_reset_mid_proc();
    do_reset();
    send_byte(8'h1C);
    @(negedge clk);
    kb_data  = 8'h32;
    kb_ready = 1'b1;
    @(posedge clk);
    #1;
    kb_ready = 1'b1;
    clrn = 1'b0;
    #1;
    checks++;
    if (nextdata_n !== 1'b1) begin failures++; $display("FAIL midrst_nextdata got=%b want=1", nextdata_n); end
    checks++;
    if ({scan_code, ext, key_down, key_event, press_count, ascii} !== 27'h0) begin
      failures++;
      $display("FAIL midrst_outputs got scan=%h ext=%b down=%b ev=%b cnt=%h ascii=%h want all 0",
               scan_code, ext, key_down, key_event, press_count, ascii);
    end
    @(negedge clk);
    kb_ready = 1'b0;
    clrn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({scan_code, press_count, key_down} !== 17'h0) begin
      failures++;
      $display("FAIL midrst_discard got scan=%h cnt=%0d down=%b want 00 0 0", scan_code, press_count, key_down);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    checks++;
    if (err_ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b want=0", err_ovf); end
    @(negedge clk);
    kb_overflow = 1'b1;
    @(negedge clk);
    kb_overflow = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (err_ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b want=1", err_ovf); end
    send_byte(8'h1C);
    checks++;
    if (err_ovf !== 1'b1) begin failures++; $display("FAIL ovf_hold got=%b want=1", err_ovf); end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_typematic();
    test_shift();
    test_extended();
    test_ascii_map();
    test_wrap();
    test_reset_mid_proc();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of press counter.
REQ-002 SHALL have ports: clk  input  1  system clock, all state on posedge.
REQ-003 SHALL have port clrn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port kb_data  input  8  byte at head of keyboard FIFO, valid while kb_ready=1.
REQ-005 SHALL have port kb_ready  input  1  keyboard FIFO non-empty.
REQ-006 SHALL have port kb_overflow  input  1  keyboard FIFO overflow flag.
REQ-007 SHALL have port nextdata_n  output  1  active-low pop request to keyboard FIFO.
REQ-008 SHALL have port scan_code  output  8  last accepted make code.
REQ-009 SHALL have port ext  output  1  last make code was E0-prefixed.
REQ-010 SHALL have port ascii  output  8  ASCII of scan_code under current shift state, 0x00 if unmapped.
REQ-011 SHALL have port key_down  output  1  last-made key still held.
REQ-012 SHALL have port key_event  output  1  one-cycle pulse on new press or release of held key.
REQ-013 SHALL have port press_count  output  CNT_W  count of distinct presses, wraps.
REQ-014 SHALL have port err_ovf  output  1  sticky copy of kb_overflow.

Function
REQ-015 SHALL use FSM states IDLE, PROC; nextdata_n = ~(kb_ready & state==IDLE), combinational.
REQ-016 SHALL, in IDLE with kb_ready=1, latch kb_data into byte register on that edge and enter PROC; pop occurs on same edge.
REQ-017 SHALL decode latched byte in PROC, update outputs on that edge, return to IDLE (max one byte per 2 cycles; output latency 2 edges from kb_ready).
REQ-018 SHALL track prefix flags e0_seen, f0_seen: byte 0xE0 sets e0_seen; 0xF0 sets f0_seen; repeated prefixes keep flags set.
REQ-019 SHALL treat any other byte as code C completing a sequence, then clear both prefix flags.
REQ-020 SHALL discard bytes 0x00 and 0xFF (keyboard error) and clear both prefix flags, no output change.
REQ-021 SHALL treat non-ext C in {0x12, 0x59} as shift: make sets, break clears its own bit; shift = OR of both; no other output change.
REQ-022 SHALL, on make (f0_seen=0) where key_down=1 and {e0_seen,C}=={ext,scan_code}, treat as typematic repeat: no output change.
REQ-023 SHALL, on any other make, set scan_code=C, ext=e0_seen, key_down=1, press_count+=1 (mod 2^CNT_W), pulse key_event.
REQ-024 SHALL, on break matching {ext,scan_code} with key_down=1, clear key_down, pulse key_event; other breaks ignored.
REQ-025 SHALL compute ascii combinationally from scan_code, ext, shift; ext=1 yields 0x00.
REQ-026 SHALL map set-2 codes: letters a-z (0x1C->'a' 0x61, 0x32->'b'...), uppercase when shift; digits 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 -> '0'-'9'; 0x29->0x20; 0x5A->0x0D; 0x66->0x08; all others 0x00.
REQ-027 SHALL set err_ovf when kb_overflow=1; cleared only by reset.

Reset
REQ-028 SHALL, on clrn=0 at any time, force state=IDLE, flags=0, shift=0, scan_code=0x00, ext=0, key_down=0, key_event=0, press_count=0, err_ovf=0; nextdata_n=1 while clrn=0.
REQ-029 SHALL discard a byte latched in PROC when reset asserts mid-operation.

Structure
REQ-030 SHALL place prefix constants (0xE0, 0xF0), shift codes, and FSM state encoding in shared package ps2_pkg.
REQ-031 SHALL implement ASCII lookup as sub-module scancode_to_ascii (pure combinational ROM: scan_code, ext, shift -> ascii).

Verification
REQ-032 SHALL test press/release: bytes 1C, F0, 1C -> scan_code=0x1C, ascii=0x61, press_count=1, key_down 1 then 0, two key_event pulses.
REQ-033 SHALL test typematic: 1C,1C,1C,F0,1C -> press_count=1, key_event pulses=2.
REQ-034 SHALL test shift: 12, 32, F0,32, F0,12, 32 -> ascii 0x42 then later 0x62; press_count=2; shift codes never shown in scan_code.
REQ-035 SHALL test extended: E0,75, E0,F0,75 -> ext=1, scan_code=0x75, ascii=0x00, key_down 1->0; then 75 counts as new press (count+1).
REQ-036 SHALL test wrap and reset: 256 distinct presses -> press_count=0x00; clrn pulse mid-PROC -> all outputs reset values, nextdata_n=1 during reset; kb_overflow pulse -> err_ovf stays 1.
